// File: rtl/pmp_pkg.sv
`default_nettype none
// ============================================================================
// pmp_pkg
// Shared PMP encodings: A-field modes, permission bit positions, FSM states.
// Rev 1.0
// ============================================================================
package pmp_pkg;

  localparam logic [1:0] c_a_off   = 2'd0;
  localparam logic [1:0] c_a_tor   = 2'd1;
  localparam logic [1:0] c_a_na4   = 2'd2;
  localparam logic [1:0] c_a_napot = 2'd3;

  localparam int c_perm_r = 0;
  localparam int c_perm_w = 1;
  localparam int c_perm_x = 2;

  typedef enum logic [1:0] {
    c_st_idle = 2'd0,
    c_st_scan = 2'd1,
    c_st_resp = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pmp_addr_check.sv
`default_nettype none
// ============================================================================
// pmp_addr_check
// Single-entry PMP address comparator shared across the sequential scan.
// Rev 1.0
// ============================================================================
module pmp_addr_check
  import pmp_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            a_mode,
  input  logic [ADDR_WIDTH-1:0] lower,
  input  logic [ADDR_WIDTH-1:0] upper,
  input  logic [ADDR_WIDTH-1:0] mask,
  output logic                  match
);

  always_comb begin
    match = 1'b0;
    case (a_mode)
      c_a_off:   match = 1'b0;
      c_a_tor:   match = (addr >= lower) && (addr < upper);
      // NA4 covers the naturally aligned 4-byte word holding the entry address
      c_a_na4:   match = (addr[ADDR_WIDTH-1:2] == upper[ADDR_WIDTH-1:2]);
      c_a_napot: match = ((addr ^ upper) & mask) == '0;
      default:   match = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pmp_seq_checker.sv
`default_nettype none
// ============================================================================
// pmp_seq_checker
// Sequential PMP checker: scans one entry per cycle, lowest matching index wins.
// Rev 1.0
// ============================================================================
module pmp_seq_checker
  import pmp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_ENTRIES = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [ADDR_WIDTH-1:0]                 req_addr,
  input  logic [2:0]                            req_type,
  input  logic                                  req_mmode,
  input  logic [NUM_ENTRIES-1:0][1:0]           cfg_a,
  input  logic [NUM_ENTRIES-1:0][2:0]           cfg_rwx,
  input  logic [NUM_ENTRIES-1:0]                cfg_l,
  input  logic [NUM_ENTRIES-1:0][ADDR_WIDTH-1:0] cfg_addr,
  input  logic                                  cfg_update,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic                                  rsp_allow,
  output logic                                  rsp_hit,
  output logic [$clog2(NUM_ENTRIES)-1:0]        rsp_idx
);

  localparam int                    c_idx_w    = $clog2(NUM_ENTRIES);
  localparam logic [c_idx_w-1:0]    c_idx_one  = c_idx_w'(1);
  localparam logic [c_idx_w-1:0]    c_last_idx = c_idx_w'(NUM_ENTRIES - 1);
  localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

  state_t                  r_state, w_state_nxt;
  logic [c_idx_w-1:0]      r_idx, w_idx_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
  logic [2:0]              r_type, w_type_nxt;
  logic                    r_mmode, w_mmode_nxt;
  logic                    r_hit, w_hit_nxt;
  logic [c_idx_w-1:0]      r_rsp_idx, w_rsp_idx_nxt;
  logic                    r_allow, w_allow_nxt;

  logic [ADDR_WIDTH-1:0]   w_upper, w_lower, w_mask;
  logic [2:0]              w_rwx;
  logic                    w_match, w_perm_ok, w_allow;

  assign w_upper = cfg_addr[r_idx];
  assign w_lower = (r_idx == '0) ? '0 : cfg_addr[r_idx - c_idx_one];
  // Trailing ones of the entry address select the NAPOT region size
  assign w_mask  = ~(w_upper ^ (w_upper + c_addr_one));
  assign w_rwx   = cfg_rwx[r_idx];

  pmp_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_check (
    .addr   (r_addr),
    .a_mode (cfg_a[r_idx]),
    .lower  (w_lower),
    .upper  (w_upper),
    .mask   (w_mask),
    .match  (w_match)
  );

  assign w_perm_ok = (r_type[c_perm_r] & w_rwx[c_perm_r]) |
                     (r_type[c_perm_w] & w_rwx[c_perm_w]) |
                     (r_type[c_perm_x] & w_rwx[c_perm_x]);
  // Unlocked entries do not constrain machine mode
  assign w_allow   = (!r_mmode || cfg_l[r_idx]) ? w_perm_ok : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_st_idle;
      r_idx     <= '0;
      r_addr    <= '0;
      r_type    <= '0;
      r_mmode   <= 1'b0;
      r_hit     <= 1'b0;
      r_rsp_idx <= '0;
      r_allow   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_addr    <= w_addr_nxt;
      r_type    <= w_type_nxt;
      r_mmode   <= w_mmode_nxt;
      r_hit     <= w_hit_nxt;
      r_rsp_idx <= w_rsp_idx_nxt;
      r_allow   <= w_allow_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_addr_nxt    = r_addr;
    w_type_nxt    = r_type;
    w_mmode_nxt   = r_mmode;
    w_hit_nxt     = r_hit;
    w_rsp_idx_nxt = r_rsp_idx;
    w_allow_nxt   = r_allow;
    case (r_state)
      c_st_idle: begin
        if (req_valid) begin
          w_addr_nxt  = req_addr;
          w_type_nxt  = req_type;
          w_mmode_nxt = req_mmode;
          w_idx_nxt   = '0;
          w_state_nxt = c_st_scan;
        end
      end
      c_st_scan: begin
        // A config change invalidates everything examined so far, including a match this cycle
        if (cfg_update) begin
          w_idx_nxt = '0;
        end else if (w_match) begin
          w_hit_nxt     = 1'b1;
          w_rsp_idx_nxt = r_idx;
          w_allow_nxt   = w_allow;
          w_state_nxt   = c_st_resp;
        end else if (r_idx == c_last_idx) begin
          w_hit_nxt     = 1'b0;
          w_rsp_idx_nxt = '0;
          w_allow_nxt   = r_mmode;
          w_state_nxt   = c_st_resp;
        end else begin
          w_idx_nxt = r_idx + c_idx_one;
        end
      end
      c_st_resp: begin
        if (rsp_ready) begin
          w_state_nxt = c_st_idle;
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  assign req_ready = (r_state == c_st_idle) && !rst;
  assign rsp_valid = (r_state == c_st_resp);
  assign rsp_hit   = r_hit;
  assign rsp_idx   = r_rsp_idx;
  assign rsp_allow = r_allow;

endmodule
`default_nettype wire

// File: tb/tb_pmp_seq_checker.sv
`default_nettype none
// ============================================================================
// tb_pmp_seq_checker
// Scoreboard bench for the sequential PMP checker (16 entries, 32-bit addresses).
// Rev 1.0
// ============================================================================
module tb_pmp_seq_checker;

  localparam int AW = 32;
  localparam int N  = 16;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic [AW-1:0]         req_addr = '0;
  logic [2:0]            req_type = '0;
  logic                  req_mmode = 1'b0;
  logic [N-1:0][1:0]     cfg_a;
  logic [N-1:0][2:0]     cfg_rwx;
  logic [N-1:0]          cfg_l;
  logic [N-1:0][AW-1:0]  cfg_addr;
  logic                  cfg_update = 1'b0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic                  rsp_allow;
  logic                  rsp_hit;
  logic [3:0]            rsp_idx;

  typedef struct {
    logic       hit;
    logic [3:0] idx;
    logic       allow;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pmp_seq_checker #(
    .ADDR_WIDTH  (AW),
    .NUM_ENTRIES (N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_type   (req_type),
    .req_mmode  (req_mmode),
    .cfg_a      (cfg_a),
    .cfg_rwx    (cfg_rwx),
    .cfg_l      (cfg_l),
    .cfg_addr   (cfg_addr),
    .cfg_update (cfg_update),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_allow  (rsp_allow),
    .rsp_hit    (rsp_hit),
    .rsp_idx    (rsp_idx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      cfg_a[i]    = 2'd0;
      cfg_rwx[i]  = 3'b000;
      cfg_l[i]    = 1'b0;
      cfg_addr[i] = '0;
    end
  endtask

  task automatic set_entry(input int i, input logic [1:0] a, input logic [2:0] rwx,
                           input logic l, input logic [AW-1:0] addr);
    cfg_a[i]    = a;
    cfg_rwx[i]  = rwx;
    cfg_l[i]    = l;
    cfg_addr[i] = addr;
  endtask

  // Issues one request, scores the response; upd_at >= 0 pulses cfg_update in that scan cycle
  task automatic do_req(input string name, input logic [AW-1:0] addr, input logic [2:0] typ,
                        input logic mm, input logic ehit, input int eidx, input logic eallow,
                        input int upd_at, input int hold);
    exp_t e;
    exp_t got;
    int   lat;
    int   wait_c;
    e.hit   = ehit;
    e.idx   = ehit ? 4'(eidx) : 4'd0;
    e.allow = eallow;
    e.lat   = ehit ? eidx + 1 : N;
    if (upd_at >= 0) e.lat = e.lat + upd_at + 1;

    req_addr  = addr;
    req_type  = typ;
    req_mmode = mm;
    req_valid = 1'b1;
    wait_c = 0;
    while (!req_ready && wait_c < 50) begin
      step();
      wait_c++;
    end
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s accept: req_ready=%b expected 1", name, req_ready);
      req_valid = 1'b0;
      return;
    end
    step();
    req_valid = 1'b0;
    sb.push_back(e);

    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 64) begin
      if (lat == upd_at) cfg_update = 1'b1;
      step();
      cfg_update = 1'b0;
      lat++;
    end
    got = sb.pop_front();
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s timeout: rsp_valid=%b expected 1", name, rsp_valid);
      return;
    end
    total++;
    if (lat != got.lat) begin
      bad++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, got.lat);
    end
    total++;
    if (rsp_hit !== got.hit) begin
      bad++;
      $display("FAIL %s hit: got %b expected %b", name, rsp_hit, got.hit);
    end
    total++;
    if (rsp_idx !== got.idx) begin
      bad++;
      $display("FAIL %s idx: got %0d expected %0d", name, rsp_idx, got.idx);
    end
    total++;
    if (rsp_allow !== got.allow) begin
      bad++;
      $display("FAIL %s allow: got %b expected %b", name, rsp_allow, got.allow);
    end

    for (int c = 0; c < hold; c++) begin
      step();
      total++;
      if (rsp_valid !== 1'b1 || rsp_hit !== got.hit || rsp_idx !== got.idx || rsp_allow !== got.allow) begin
        bad++;
        $display("FAIL %s hold%0d: valid=%b hit=%b idx=%0d allow=%b expected 1/%b/%0d/%b",
                 name, c, rsp_valid, rsp_hit, rsp_idx, rsp_allow, got.hit, got.idx, got.allow);
      end
    end

    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s release: rsp_valid=%b req_ready=%b expected 0/1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_hit !== 1'b0 ||
        rsp_idx !== 4'd0 || rsp_allow !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b valid=%b hit=%b idx=%0d allow=%b expected all 0",
               req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_allow);
    end
    step();
    step();
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: req_ready=%b expected 1", req_ready);
    end
  endtask

  task automatic test_napot();
    clear_cfg();
    set_entry(3, 2'd3, 3'b001, 1'b0, 32'h0000_10FF);
    do_req("napot_u_read",   32'h0000_1080, 3'b001, 1'b0, 1'b1, 3, 1'b1, -1, 0);
    do_req("napot_u_write",  32'h0000_1080, 3'b010, 1'b0, 1'b1, 3, 1'b0, -1, 0);
    do_req("napot_m_write",  32'h0000_1080, 3'b010, 1'b1, 1'b1, 3, 1'b1, -1, 0);
    do_req("napot_top_edge", 32'h0000_11FF, 3'b001, 1'b0, 1'b1, 3, 1'b1, -1, 0);
    do_req("napot_outside",  32'h0000_1200, 3'b001, 1'b0, 1'b0, 0, 1'b0, -1, 0);
    cfg_l[3] = 1'b1;
    do_req("napot_m_wr_lock", 32'h0000_1080, 3'b010, 1'b1, 1'b1, 3, 1'b0, -1, 0);
    do_req("napot_m_rd_lock", 32'h0000_1080, 3'b001, 1'b1, 1'b1, 3, 1'b1, -1, 0);
  endtask

  task automatic test_tor();
    clear_cfg();
    set_entry(0, 2'd1, 3'b000, 1'b0, 32'h0000_0100);
    set_entry(1, 2'd1, 3'b011, 1'b0, 32'h0000_0200);
    do_req("tor_mid",     32'h0000_0150, 3'b001, 1'b0, 1'b1, 1, 1'b1, -1, 0);
    do_req("tor_zero",    32'h0000_0000, 3'b001, 1'b0, 1'b1, 0, 1'b0, -1, 0);
    do_req("tor_below",   32'h0000_00FF, 3'b001, 1'b1, 1'b1, 0, 1'b1, -1, 0);
    do_req("tor_lower",   32'h0000_0100, 3'b100, 1'b0, 1'b1, 1, 1'b0, -1, 0);
    do_req("tor_top_u",   32'h0000_0200, 3'b001, 1'b0, 1'b0, 0, 1'b0, -1, 0);
    do_req("tor_top_m",   32'h0000_0200, 3'b001, 1'b1, 1'b0, 0, 1'b1, -1, 0);
  endtask

  task automatic test_priority();
    clear_cfg();
    set_entry(2, 2'd3, 3'b100, 1'b0, 32'h0000_10FF);
    set_entry(5, 2'd3, 3'b111, 1'b0, 32'h0000_1FFF);
    do_req("prio_x",      32'h0000_1010, 3'b100, 1'b0, 1'b1, 2, 1'b1, -1, 0);
    do_req("prio_w",      32'h0000_1010, 3'b010, 1'b0, 1'b1, 2, 1'b0, -1, 0);
    do_req("prio_only5",  32'h0000_3000, 3'b010, 1'b0, 1'b1, 5, 1'b1, -1, 0);
  endtask

  task automatic test_cfg_update();
    do_req("upd_restart", 32'h0000_3000, 3'b010, 1'b0, 1'b1, 5, 1'b1, 2, 5);
    do_req("upd_on_match", 32'h0000_1010, 3'b100, 1'b0, 1'b1, 2, 1'b1, 2, 0);
  endtask

  task automatic test_back_to_back();
    do_req("b2b_a", 32'h0000_1010, 3'b100, 1'b0, 1'b1, 2, 1'b1, -1, 0);
    do_req("b2b_b", 32'h0000_3FFF, 3'b001, 1'b0, 1'b1, 5, 1'b1, -1, 1);
  endtask

  task automatic test_reset_mid_scan();
    int stale;
    clear_cfg();
    set_entry(3, 2'd3, 3'b001, 1'b0, 32'h0000_10FF);
    req_addr  = 32'h0000_1080;
    req_type  = 3'b001;
    req_mmode = 1'b0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_assert: rsp_valid=%b req_ready=%b expected 0/0", rsp_valid, req_ready);
    end
    step();
    step();
    rst = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_ready: req_ready=%b expected 1", req_ready);
    end
    stale = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (rsp_valid !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL midrst_stale: rsp_valid high in %0d cycles expected 0", stale);
    end
    do_req("midrst_after", 32'h0000_1080, 3'b001, 1'b0, 1'b1, 3, 1'b1, -1, 0);
  endtask

  initial begin
    clear_cfg();
    test_reset();
    test_napot();
    test_tor();
    test_priority();
    test_cfg_update();
    test_back_to_back();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pmp_seq_checker.md
PMP_SEQ_CHECKER -- requirements
Module: pmp_seq_checker

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of request and PMP address.
REQ-002 SHALL have parameter NUM_ENTRIES, default 16, number of PMP entries scanned; legal range 2..64.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid / req_ready, in / out, 1 each, request handshake.
REQ-006 SHALL have port req_addr, in, ADDR_WIDTH, address to check.
REQ-007 SHALL have port req_type, in, 3, one-hot access type: bit0 R, bit1 W, bit2 X.
REQ-008 SHALL have port req_mmode, in, 1, request issued in machine mode.
REQ-009 SHALL have port cfg_a, in, NUM_ENTRIES x 2, per-entry A field: OFF 0, TOR 1, NA4 2, NAPOT 3.
REQ-010 SHALL have port cfg_rwx, in, NUM_ENTRIES x 3, per-entry permission bits with the same bit order as req_type.
REQ-011 SHALL have port cfg_l, in, NUM_ENTRIES x 1, per-entry lock bit.
REQ-012 SHALL have port cfg_addr, in, NUM_ENTRIES x ADDR_WIDTH, per-entry PMP address.
REQ-013 SHALL have port cfg_update, in, 1, one-cycle pulse indicating that configuration changed.
REQ-014 SHALL have port rsp_valid / rsp_ready, out / in, 1 each, response handshake.
REQ-015 SHALL have port rsp_allow, out, 1, access permitted.
REQ-016 SHALL have port rsp_hit, out, 1, some entry matched.
REQ-017 SHALL have port rsp_idx, out, clog2(NUM_ENTRIES), index of the matching entry; 0 when rsp_hit is 0.

Function
REQ-018 SHALL use a three-state FSM: IDLE, SCAN, RESP.
REQ-019 SHALL assert req_ready only in IDLE; a transfer occurs when req_valid and req_ready are both high, and it SHALL register addr, type and mmode and then move to SCAN with idx = 0.
REQ-020 SHALL, in SCAN, evaluate exactly one entry per cycle (entry idx) through a single shared address-check instance.
REQ-021 SHALL, for TOR, use cfg_addr[idx-1] as the lower bound, or 0 when idx = 0; the match range is lower <= addr < cfg_addr[idx].
REQ-022 SHALL derive the NAPOT mask for entry idx as ~(cfg_addr[idx] ^ (cfg_addr[idx] + 1)), truncated to ADDR_WIDTH.
REQ-023 SHALL treat an entry with A = OFF as never matching.
REQ-024 SHALL, on the first matching entry idx, register hit = 1 and idx, then go to RESP; the lowest index wins.
REQ-025 SHALL compute allow on a hit as: (req_type & cfg_rwx[idx]) != 0 when req_mmode = 0 or cfg_l[idx] = 1; otherwise allow = 1.
REQ-026 SHALL, when no entry matches by idx = NUM_ENTRIES-1, go to RESP with hit = 0, idx = 0 and allow = req_mmode.
REQ-027 SHALL produce a response with latency = (matching index + 1) cycles after acceptance, or NUM_ENTRIES cycles when nothing matches.
REQ-028 SHALL hold rsp_valid high in RESP, keeping all response fields stable until rsp_ready; on handshake it SHALL return to IDLE.
REQ-029 SHALL, on cfg_update during SCAN, discard partial results and restart at idx = 0 on the next cycle; a cfg_update in the same cycle as a match wins over the match.
REQ-030 SHALL ignore cfg_update in IDLE and RESP; an already-registered response is not changed.
REQ-031 SHALL use configuration inputs combinationally; they are stable except across a cfg_update pulse.
REQ-032 SHALL not accept a new request in the cycle a response completes; the earliest new acceptance is the following IDLE cycle.

Reset
REQ-033 SHALL, on rst assertion asynchronously: set state IDLE, idx 0, and drive req_ready 0 while in reset.
REQ-034 SHALL hold rsp_valid 0, rsp_allow 0, rsp_hit 0 and rsp_idx 0 during reset.
REQ-035 SHALL abandon any scan or pending response on reset with no further output; req_ready SHALL rise in the first cycle after rst deasserts.

Structure
REQ-036 SHALL place the A-field encodings, permission bit positions and FSM state enum in a shared package pmp_pkg.
REQ-037 SHALL instantiate exactly one sub-module, pmp_addr_check, as the shared comparator; the index counter, lower-bound mux, mask generation and FSM SHALL live in the top level.

Verification
REQ-038 SHALL cover: N=16, entry 3 NAPOT addr 0x0000_10FF (mask 0xFFFF_FE00), rwx = R, U-mode read of 0x0000_1080 -> rsp_hit 1, idx 3, allow 1, 4 cycles after acceptance.
REQ-039 SHALL cover: same setup with a U-mode write -> hit 1, idx 3, allow 0; M-mode write with L = 0 -> allow 1.
REQ-040 SHALL cover: entry 0 TOR addr 0x100, entry 1 TOR addr 0x200, access 0x150 -> idx 1; access 0x200 -> no hit, allow = req_mmode, latency 16.
REQ-041 SHALL cover: entries 2 and 5 both matching -> idx 2 is reported.
REQ-042 SHALL cover: cfg_update at scan cycle 2 -> scan restarts and latency becomes 3 + (match index + 1); with rsp_ready held low for 5 cycles, the response stays stable.
REQ-043 SHALL cover: rst asserted mid-SCAN -> rsp_valid stays 0, req_ready is 1 on the first cycle after release, and no stale response appears.
